// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state type and default sizing for the memory arbiter
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, CMD, RESP, TOUT} state_t;
   localparam int DEF_NB_REQ = 3;
   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_TIMEOUT_CYCLES = 255;
   localparam int CNT_WIDTH = 16;
endpackage

// File: rtl/rr_prio_sel.sv
// rr_prio_sel: round-robin pick of the first active request after last_winner
module rr_prio_sel #(
   parameter int NB_REQ = 3,
   localparam int IW = $clog2(NB_REQ)
) (
   input  logic [NB_REQ-1:0] req,
   input  logic [IW-1:0]     last_winner,
   output logic              valid,
   output logic [IW-1:0]     index
);
   // Scan farthest-first so the nearest request after last_winner overwrites last
   always_comb begin
      valid = 1'b0;
      index = '0;
      for (int k = NB_REQ; k >= 1; k--)
         if (req[(int'(last_winner) + k) % NB_REQ]) begin
            valid = 1'b1;
            index = IW'((int'(last_winner) + k) % NB_REQ);
         end
   end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-port round-robin arbiter onto one downstream memory port,
// one outstanding transaction, with response timeout
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NB_REQ = DEF_NB_REQ,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   localparam int IW = $clog2(NB_REQ),
   localparam int BW = DATA_WIDTH / 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NB_REQ-1:0]                    req_i,
   input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]    addr_i,
   input  logic [NB_REQ-1:0]                    we_i,
   input  logic [NB_REQ-1:0][BW-1:0]            be_i,
   input  logic [NB_REQ-1:0][DATA_WIDTH-1:0]    wdata_i,
   output logic [NB_REQ-1:0]                    gnt_o,
   output logic [NB_REQ-1:0]                    rvalid_o,
   output logic [DATA_WIDTH-1:0]                rdata_o,
   output logic                                 err_o,
   output logic                                 m_req_o,
   output logic [ADDR_WIDTH-1:0]                m_addr_o,
   output logic                                 m_we_o,
   output logic [BW-1:0]                        m_be_o,
   output logic [DATA_WIDTH-1:0]                m_wdata_o,
   input  logic                                 m_gnt_i,
   input  logic                                 m_rvalid_i,
   input  logic                                 m_err_i,
   input  logic [DATA_WIDTH-1:0]                m_rdata_i
);
   localparam logic [CNT_WIDTH-1:0] TO = CNT_WIDTH'(TIMEOUT_CYCLES);
   state_t state;
   logic [IW-1:0] owner, last_winner, sel_idx;
   logic sel_valid;
   logic [CNT_WIDTH-1:0] cnt;
   logic cmd_ok, resp_ok, tout;
   logic [NB_REQ-1:0] owner_oh;
   rr_prio_sel #(.NB_REQ(NB_REQ)) u_sel (
      .req(req_i),
      .last_winner(last_winner),
      .valid(sel_valid),
      .index(sel_idx)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         last_winner <= IW'(NB_REQ - 1);
         owner <= '0;
         cnt <= '0;
         m_addr_o <= '0;
         m_we_o <= 1'b0;
         m_be_o <= '0;
         m_wdata_o <= '0;
      end else begin
         case (state)
            IDLE: if (sel_valid) begin
               owner <= sel_idx;
               m_addr_o <= addr_i[sel_idx];
               m_we_o <= we_i[sel_idx];
               m_be_o <= be_i[sel_idx];
               m_wdata_o <= wdata_i[sel_idx];
               state <= CMD;
            end
            CMD: if (m_gnt_i) begin
               last_winner <= owner;
               cnt <= '0;
               state <= RESP;
            end
            RESP: if (m_rvalid_i) state <= IDLE;
            else begin
               cnt <= (cnt == TO) ? cnt : cnt + 1'b1;
               if (cnt + 1'b1 >= TO) state <= TOUT;
            end
            default: state <= IDLE;
         endcase
      end
   end
   // Handshake outputs follow the downstream inputs in the same cycle; rst masks them
   assign cmd_ok = (state == CMD) && m_gnt_i && !rst;
   assign resp_ok = (state == RESP) && m_rvalid_i && !rst;
   assign tout = (state == TOUT) && !rst;
   assign owner_oh = NB_REQ'(1) << owner;
   assign m_req_o = (state == CMD);
   assign gnt_o = cmd_ok ? owner_oh : '0;
   assign rvalid_o = (resp_ok || tout) ? owner_oh : '0;
   assign rdata_o = resp_ok ? m_rdata_i : '0;
   assign err_o = resp_ok ? m_err_i : tout;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transactions checked against a
// transaction-level round-robin / timeout model
module tb_mem_arbiter;
   localparam int NB = 3;
   localparam int TO = 4;
   logic clk = 1'b0;
   logic rst;
   logic [NB-1:0] req_i, we_i, gnt_o, rvalid_o;
   logic [NB-1:0][31:0] addr_i, wdata_i;
   logic [NB-1:0][3:0] be_i;
   logic [31:0] rdata_o, m_addr_o, m_wdata_o, m_rdata_i;
   logic err_o, m_req_o, m_we_o, m_gnt_i, m_rvalid_i, m_err_i;
   logic [3:0] m_be_o;
   int n_vec = 0, n_err = 0, last_w = NB - 1, w;
   mem_arbiter #(.NB_REQ(NB), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .we_i(we_i), .be_i(be_i),
      .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
      .m_req_o(m_req_o), .m_addr_o(m_addr_o), .m_we_o(m_we_o), .m_be_o(m_be_o),
      .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i), .m_err_i(m_err_i),
      .m_rdata_i(m_rdata_i)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic int rr(input logic [NB-1:0] rv, input int last);
      for (int k = 1; k <= NB; k++)
         if (rv[(last + k) % NB]) return (last + k) % NB;
      return -1;
   endfunction
   task automatic do_txn(input logic [NB-1:0] rv, input int stall, input int d, input bit drop,
                         input logic [31:0] a0, input logic [31:0] rd0);
      logic [31:0] ea, ed, rd;
      logic [3:0] eb;
      logic ew, e;
      int wn;
      for (int i = 0; i < NB; i++) begin
         addr_i[i] = $urandom; wdata_i[i] = $urandom; we_i[i] = 1'($urandom); be_i[i] = 4'($urandom);
      end
      if (a0 != 0) addr_i[0] = a0;
      rd = (rd0 != 0) ? rd0 : $urandom;
      e = (rd0 != 0) ? 1'b0 : 1'($urandom);
      wn = rr(rv, last_w);
      ea = addr_i[wn]; ed = wdata_i[wn]; eb = be_i[wn]; ew = we_i[wn];
      req_i = rv;
      m_rvalid_i = 1'($urandom);
      m_rdata_i = $urandom;
      #1;
      check("idle_rvalid", rvalid_o, 0);
      check("idle_mreq", m_req_o, 0);
      tick();
      m_rvalid_i = 1'b0;
      for (int s = 0; s < stall; s++) begin
         if (drop) begin req_i = NB'($urandom); addr_i[wn] = $urandom; end
         #1;
         check("stall_mreq", m_req_o, 1);
         check("stall_addr", m_addr_o, ea);
         check("stall_gnt", gnt_o, 0);
         tick();
      end
      m_gnt_i = 1'b1;
      #1;
      check("cmd_mreq", m_req_o, 1);
      check("gnt", gnt_o, NB'(1) << wn);
      check("m_addr", m_addr_o, ea);
      check("m_wdata", m_wdata_o, ed);
      check("m_be_we", {m_be_o, m_we_o}, {eb, ew});
      tick();
      m_gnt_i = 1'b0;
      last_w = wn;
      w = wn;
      for (int c = 0; c < TO; c++) begin
         if (c == d) begin
            m_rvalid_i = 1'b1; m_rdata_i = rd; m_err_i = e;
            #1;
            check("rvalid", rvalid_o, NB'(1) << wn);
            check("rdata", rdata_o, rd);
            check("err", err_o, e);
            check("resp_gnt", gnt_o, 0);
            tick();
            m_rvalid_i = 1'b0; m_err_i = 1'b0;
            return;
         end
         m_rdata_i = $urandom;
         #1;
         check("wait_rvalid", rvalid_o, 0);
         check("wait_rdata_err", {rdata_o, err_o}, 0);
         check("wait_mreq", m_req_o, 0);
         tick();
      end
      m_rvalid_i = 1'($urandom); m_rdata_i = $urandom; m_err_i = 1'b0;
      #1;
      check("tout_rvalid", rvalid_o, NB'(1) << wn);
      check("tout_err", err_o, 1);
      check("tout_rdata", rdata_o, 0);
      tick();
      m_rvalid_i = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
   initial begin
      rst = 1'b1; req_i = '0; addr_i = '0; we_i = '0; be_i = '0; wdata_i = '0;
      m_gnt_i = 1'b0; m_rvalid_i = 1'b0; m_err_i = 1'b0; m_rdata_i = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      check("rst_outs", {gnt_o, rvalid_o, rdata_o, err_o, m_req_o}, 0);
      check("rst_hold", {m_addr_o, m_wdata_o, m_be_o, m_we_o}, 0);
      tick();
      for (int i = 0; i < 6; i++) do_txn(3'b111, 0, 0, 0, 0, 0);
      do_txn(3'b001, 0, 1, 0, 32'h0010_0040, 32'hDEAD_BEEF);
      do_txn(3'b011, 0, 9, 0, 0, 0);
      do_txn(3'b101, 1, 0, 0, 0, 0);
      do_txn(3'b010, 10, 2, 1, 0, 0);
      req_i = 3'b010;
      tick();
      m_gnt_i = 1'b1;
      tick();
      m_gnt_i = 1'b0; rst = 1'b1; m_rvalid_i = 1'b1; m_rdata_i = 32'h1234_5678;
      #1;
      check("rst_resp_rvalid", {rvalid_o, gnt_o}, 0);
      tick();
      rst = 1'b0; req_i = '0;
      #1;
      check("post_rst_outs", {gnt_o, rvalid_o, rdata_o, err_o, m_req_o}, 0);
      check("post_rst_hold", m_addr_o, 0);
      tick();
      m_rvalid_i = 1'b0;
      last_w = NB - 1;
      do_txn(3'b111, 0, 1, 0, 0, 0);
      do_txn(3'b100, 0, 0, 0, 0, 0);
      for (int t = 0; t < 40; t++)
         do_txn(NB'($urandom_range(1, 7)), $urandom_range(0, 3), $urandom_range(0, 5),
                1'($urandom), 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
